// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - sequencer launching and tracking the multi-cycle mult/div units
module muldiv_ctrl #(
    parameter int MULT_LAT = 33,
    parameter int DIV_LAT  = 35
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_start,
    input  logic        op_div,
    input  logic [31:0] divisor,
    input  logic        abort,
    input  logic [31:0] mult_hi_in,
    input  logic [31:0] mult_lo_in,
    input  logic [31:0] div_hi_in,
    input  logic [31:0] div_lo_in,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] mt_wdata,
    output logic        mult_init,
    output logic        div_init,
    output logic        mult_stop,
    output logic        div_stop,
    output logic        stall,
    output logic        done,
    output logic        div_zero,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // The counter is preloaded with LAT-1 so that WAIT lasts exactly LAT cycles.
    localparam logic [5:0] MULT_LOAD = 6'(MULT_LAT - 1);
    localparam logic [5:0] DIV_LOAD  = 6'(DIV_LAT - 1);

    state_t      state, state_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic        sel, sel_nxt;
    logic        capture;

    // State, counter and unit-select registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            sel   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sel   <= sel_nxt;
        end
    end

    // Next-state logic plus the combinational pulses, stall and busy.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel;
        capture   = 1'b0;
        mult_init = 1'b0;
        div_init  = 1'b0;
        mult_stop = 1'b0;
        div_stop  = 1'b0;
        stall     = 1'b0;
        done      = 1'b0;
        div_zero  = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                done      = (state == S_DONE);
                state_nxt = S_IDLE;
                // rst gating keeps stall/div_zero quiet while reset is held.
                if (rst && !abort && op_start) begin
                    if (op_div && (divisor == '0)) begin
                        div_zero = 1'b1;
                    end else begin
                        sel_nxt   = op_div;
                        cnt_nxt   = op_div ? DIV_LOAD : MULT_LOAD;
                        state_nxt = S_LAUNCH;
                        stall     = 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                busy      = 1'b1;
                stall     = 1'b1;
                mult_init = !sel;
                div_init  = sel;
                if (abort) begin
                    mult_stop = !sel;
                    div_stop  = sel;
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                busy  = 1'b1;
                stall = 1'b1;
                if (abort) begin
                    mult_stop = !sel;
                    div_stop  = sel;
                    state_nxt = S_IDLE;
                end else if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt - 6'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // HI/LO: unit result capture takes priority over MTHI/MTLO writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (capture) begin
            hi <= sel ? div_hi_in : mult_hi_in;
            lo <= sel ? div_lo_in : mult_lo_in;
        end else begin
            if (mthi_we) hi <= mt_wdata;
            if (mtlo_we) lo <= mt_wdata;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - table-driven self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;

    logic        clk;
    logic        rst;
    logic        op_start;
    logic        op_div;
    logic [31:0] divisor;
    logic        abort;
    logic [31:0] mult_hi_in, mult_lo_in, div_hi_in, div_lo_in;
    logic        mthi_we, mtlo_we;
    logic [31:0] mt_wdata;
    logic        mult_init, div_init, mult_stop, div_stop;
    logic        stall, done, div_zero, busy;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_ctrl #(.MULT_LAT(33), .DIV_LAT(35)) dut (
        .clk(clk), .rst(rst), .op_start(op_start), .op_div(op_div),
        .divisor(divisor), .abort(abort),
        .mult_hi_in(mult_hi_in), .mult_lo_in(mult_lo_in),
        .div_hi_in(div_hi_in), .div_lo_in(div_lo_in),
        .mthi_we(mthi_we), .mtlo_we(mtlo_we), .mt_wdata(mt_wdata),
        .mult_init(mult_init), .div_init(div_init),
        .mult_stop(mult_stop), .div_stop(div_stop),
        .stall(stall), .done(done), .div_zero(div_zero), .busy(busy),
        .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        is_div;
        logic [31:0] dvsr;
        logic [31:0] hi_in;
        logic [31:0] lo_in;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        int          abort_at;
        int          mt_at;
        logic [31:0] mt_data;
        int          exp_init;
        int          exp_done;
        int          exp_stop;
        int          exp_zero;
        int          exp_stall;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mt_preload(input logic [31:0] h, input logic [31:0] l);
        mthi_we = 1'b1; mt_wdata = h;
        @(posedge clk); #1;
        mthi_we = 1'b0; mtlo_we = 1'b1; mt_wdata = l;
        @(posedge clk); #1;
        mtlo_we = 1'b0; mt_wdata = '0;
    endtask

    task automatic run_vec(input vec_t v);
        int init_cyc = -1, done_cyc = -1, stop_cyc = -1, zero_cyc = -1;
        int init_cnt = 0, done_cnt = 0, stop_cnt = 0, zero_cnt = 0;
        int wrong_init = 0, wrong_stop = 0, stall_cnt = 0;
        mt_preload(v.pre_hi, v.pre_lo);
        mult_hi_in = v.is_div ? ~v.hi_in : v.hi_in;
        mult_lo_in = v.is_div ? ~v.lo_in : v.lo_in;
        div_hi_in  = v.is_div ? v.hi_in : ~v.hi_in;
        div_lo_in  = v.is_div ? v.lo_in : ~v.lo_in;
        for (int c = 0; c < 45; c++) begin
            op_start = (c == 0);
            op_div   = v.is_div;
            divisor  = v.dvsr;
            abort    = (c == v.abort_at);
            mthi_we  = (c == v.mt_at);
            mtlo_we  = (c == v.mt_at);
            mt_wdata = v.mt_data;
            @(negedge clk);
            if (v.is_div ? div_init : mult_init) begin
                init_cnt++; if (init_cyc < 0) init_cyc = c;
            end
            if (v.is_div ? mult_init : div_init) wrong_init++;
            if (v.is_div ? div_stop : mult_stop) begin
                stop_cnt++; if (stop_cyc < 0) stop_cyc = c;
            end
            if (v.is_div ? mult_stop : div_stop) wrong_stop++;
            if (done) begin
                done_cnt++; if (done_cyc < 0) done_cyc = c;
            end
            if (div_zero) begin
                zero_cnt++; if (zero_cyc < 0) zero_cyc = c;
            end
            if (stall) stall_cnt++;
            @(posedge clk); #1;
        end
        op_start = 1'b0; abort = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
        check({v.name, ".init_cycle"}, init_cyc, v.exp_init);
        check({v.name, ".init_count"}, init_cnt, (v.exp_init >= 0) ? 1 : 0);
        check({v.name, ".wrong_init"}, wrong_init, 0);
        check({v.name, ".done_cycle"}, done_cyc, v.exp_done);
        check({v.name, ".done_count"}, done_cnt, (v.exp_done >= 0) ? 1 : 0);
        check({v.name, ".stop_cycle"}, stop_cyc, v.exp_stop);
        check({v.name, ".stop_count"}, stop_cnt, (v.exp_stop >= 0) ? 1 : 0);
        check({v.name, ".wrong_stop"}, wrong_stop, 0);
        check({v.name, ".zero_cycle"}, zero_cyc, v.exp_zero);
        check({v.name, ".zero_count"}, zero_cnt, (v.exp_zero >= 0) ? 1 : 0);
        check({v.name, ".stall_cycles"}, stall_cnt, v.exp_stall);
        check({v.name, ".hi"}, hi, v.exp_hi);
        check({v.name, ".lo"}, lo, v.exp_lo);
        check({v.name, ".busy_after"}, {31'b0, busy}, 0);
    endtask

    initial begin
        //        name             div dvsr  hi_in  lo_in         pre_hi pre_lo abort mt  mt_data  init done stop zero stall exp_hi exp_lo
        vecs[0] = '{"div7",          1, 7,  5,     14,           0,     0,     -1,  -1, 0,        1,   37,  -1,  -1,  37,   5,     14};
        vecs[1] = '{"mult",          0, 0,  1,     32'hFFFF0000, 0,     0,     -1,  -1, 0,        1,   35,  -1,  -1,  35,   1,     32'hFFFF0000};
        vecs[2] = '{"divzero",       1, 0,  9,     9,            'hAA,  'hAA,  -1,  -1, 0,        -1,  -1,  -1,  0,   0,    'hAA,  'hAA};
        vecs[3] = '{"abort_wait",    1, 3,  9,     9,            'h11,  'h22,  10,  -1, 0,        1,   -1,  10,  -1,  11,   'h11,  'h22};
        vecs[4] = '{"abort_launch",  0, 0,  9,     9,            'h33,  'h44,  1,   -1, 0,        1,   -1,  1,   -1,  2,    'h33,  'h44};
        vecs[5] = '{"abort_first",   1, 0,  9,     9,            'h55,  'h66,  0,   -1, 0,        -1,  -1,  -1,  -1,  0,    'h55,  'h66};
        vecs[6] = '{"mt_vs_capture", 1, 2,  'h77,  'h88,         0,     0,     -1,  36, 'hCAFE,   1,   37,  -1,  -1,  37,   'h77,  'h88};
        vecs[7] = '{"mt_in_wait",    0, 0,  'hAB,  'hCD,         1,     2,     -1,  20, 'hBEEF,   1,   35,  -1,  -1,  35,   'hAB,  'hCD};

        rst = 1'b0; op_start = 1'b0; op_div = 1'b0; divisor = '0; abort = 1'b0;
        mult_hi_in = '0; mult_lo_in = '0; div_hi_in = '0; div_lo_in = '0;
        mthi_we = 1'b0; mtlo_we = 1'b0; mt_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.hi", hi, 0);
        check("reset.lo", lo, 0);
        check("reset.stall_busy_done", {29'b0, stall, busy, done}, 0);
        check("reset.inits", {30'b0, mult_init, div_init}, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Back-to-back: a DIV request in the MULT done cycle is accepted there.
        mult_hi_in = 2; mult_lo_in = 3; div_hi_in = 'h99; div_lo_in = 'h99;
        for (int c = 0; c < 39; c++) begin
            op_start = (c == 0) || (c == 35);
            op_div   = (c == 35);
            divisor  = 5;
            abort    = (c == 37);
            @(negedge clk);
            if (c == 35) begin
                check("b2b.done", {31'b0, done}, 1);
                check("b2b.stall_in_done", {31'b0, stall}, 1);
                check("b2b.hi", hi, 2);
                check("b2b.lo", lo, 3);
            end
            if (c == 36) begin
                check("b2b.div_init", {31'b0, div_init}, 1);
                check("b2b.mult_init", {31'b0, mult_init}, 0);
            end
            if (c == 37) check("b2b.div_stop", {31'b0, div_stop}, 1);
            if (c == 38) check("b2b.idle", {30'b0, busy, stall}, 0);
            @(posedge clk); #1;
        end
        op_start = 1'b0; abort = 1'b0;

        // Asynchronous reset in WAIT clears everything without a clock edge.
        op_start = 1'b1; op_div = 1'b1; divisor = 5;
        @(posedge clk); #1;
        op_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_wait.busy_before", {31'b0, busy}, 1);
        #2 rst = 1'b0;
        #1;
        check("rst_wait.hi", hi, 0);
        check("rst_wait.lo", lo, 0);
        check("rst_wait.busy", {31'b0, busy}, 0);
        check("rst_wait.stall", {31'b0, stall}, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        mthi_we = 1'b1; mt_wdata = 32'h12345678;
        @(negedge clk);
        check("mthi.before_edge", hi, 0);
        @(posedge clk); #1;
        mthi_we = 1'b0;
        check("mthi.hi", hi, 32'h12345678);
        check("mthi.lo", lo, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
